// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX operand forwarding.
// Define IDEX_FWD_EN to enable forwarding; without it, RAW hazards stall until the regfile supplies data.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [3:0]        id_alu_op,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_hold,
  input  logic              flush,
  input  logic [4:0]        exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [4:0]        memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [XLEN-1:0]   memwb_result,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [3:0]        alu_op,
  output logic [XLEN-1:0]   alu_ina,
  output logic [XLEN-1:0]   alu_inb,
  output logic [XLEN-1:0]   ex_store_data
);

  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            load_use;
  logic            load_bubble;

  assign load_use = ex_valid & ex_ctrl[1] & (ex_rd != '0) & id_valid &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

`ifdef IDEX_FWD_EN
  assign hazard_stall = load_use;

  // EX/MEM is the younger producer, so it takes precedence over MEM/WB
  always_comb begin
    op_a = rs1_data_q;
    if (rs1_q != '0) begin
      if (exmem_reg_write && exmem_rd == rs1_q)
        op_a = exmem_result;
      else if (memwb_reg_write && memwb_rd == rs1_q)
        op_a = memwb_result;
    end
  end

  always_comb begin
    op_b = rs2_data_q;
    if (rs2_q != '0) begin
      if (exmem_reg_write && exmem_rd == rs2_q)
        op_b = exmem_result;
      else if (memwb_reg_write && memwb_rd == rs2_q)
        op_b = memwb_result;
    end
  end
`else
  logic raw_ex;
  logic raw_exmem;
  logic unused_fwd;

  // Any pending producer in EX or EX/MEM blocks ID; MEM/WB is covered by the write-through regfile
  assign raw_ex    = ex_valid & ex_ctrl[3] & (ex_rd != '0) &
                     ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign raw_exmem = exmem_reg_write & (exmem_rd != '0) &
                     ((exmem_rd == id_rs1) | (exmem_rd == id_rs2));
  assign hazard_stall = load_use | (id_valid & (raw_ex | raw_exmem));

  assign op_a = rs1_data_q;
  assign op_b = rs2_data_q;
  assign unused_fwd = ^{rs1_q, rs2_q, exmem_result, memwb_rd, memwb_reg_write, memwb_result};
`endif

  assign alu_ina       = op_a;
  assign alu_inb       = ex_ctrl[0] ? imm_q : op_b;
  assign ex_store_data = op_b;

  // A stalled or invalid ID slot becomes a bubble, but a hold freezes the stage unless flushed
  assign load_bubble = flush | (~ex_hold & (hazard_stall | ~id_valid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rd      <= '0;
      ex_ctrl    <= '0;
      alu_op     <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else if (load_bubble) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rd      <= '0;
      ex_ctrl    <= '0;
      alu_op     <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
    end else if (!ex_hold) begin
      ex_valid   <= 1'b1;
      ex_pc      <= id_pc;
      ex_rd      <= id_rd;
      ex_ctrl    <= id_ctrl;
      alu_op     <= id_alu_op;
      rs1_q      <= id_rs1;
      rs2_q      <= id_rs2;
      rs1_data_q <= id_rs1_data;
      rs2_data_q <= id_rs2_data;
      imm_q      <= id_imm;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; checks both IDEX_FWD_EN builds.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [3:0]  id_alu_op;
  logic [7:0]  id_ctrl;
  logic        ex_hold, flush;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic        hazard_stall, ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd;
  logic [7:0]  ex_ctrl;
  logic [3:0]  alu_op;
  logic [31:0] alu_ina, alu_inb, ex_store_data;

  int test_count = 0;
  int fail_count = 0;

  id_ex_stage #(.XLEN(32), .CTRL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_ctrl(id_ctrl), .ex_hold(ex_hold), .flush(flush),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .alu_op(alu_op), .alu_ina(alu_ina), .alu_inb(alu_inb),
    .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] imm,
                               input logic [3:0] op, input logic [7:0] ctrl);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_op = op; id_ctrl = ctrl;
  endtask

  task automatic setBypass(input logic [4:0] xrd, input logic xw, input logic [31:0] xres,
                           input logic [4:0] wrd, input logic ww, input logic [31:0] wres);
    exmem_rd = xrd; exmem_reg_write = xw; exmem_result = xres;
    memwb_rd = wrd; memwb_reg_write = ww; memwb_result = wres;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ex_hold = 1'b0; flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 8'h00);
    setBypass(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    #1;
    checkOutput("reset_valid", {31'b0, ex_valid}, 32'h0);
    checkOutput("reset_ctrl", {24'b0, ex_ctrl}, 32'h0);
    checkOutput("reset_ina", alu_ina, 32'h0);
    checkOutput("reset_inb", alu_inb, 32'h0);
    checkOutput("reset_store", ex_store_data, 32'h0);
    checkOutput("reset_stall", {31'b0, hazard_stall}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // Plain register-register instruction
    applyStimulus(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22, 32'h4, 4'h0, 8'h08);
    #1 checkOutput("basic_stall", {31'b0, hazard_stall}, 32'h0);
    tick();
    checkOutput("basic_valid", {31'b0, ex_valid}, 32'h1);
    checkOutput("basic_pc", ex_pc, 32'h100);
    checkOutput("basic_rd", {27'b0, ex_rd}, 32'h5);
    checkOutput("basic_ctrl", {24'b0, ex_ctrl}, 32'h08);
    checkOutput("basic_ina", alu_ina, 32'h11);
    checkOutput("basic_inb", alu_inb, 32'h22);
    checkOutput("basic_store", ex_store_data, 32'h22);

    // x0 is never forwarded, then immediate selection
    applyStimulus(1'b1, 32'h104, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, 4'h0, 8'h08);
    setBypass(5'd0, 1'b1, 32'h0000FFFF, 5'd0, 1'b0, 32'h0);
    tick();
    checkOutput("x0_inb", alu_inb, 32'h0);
    checkOutput("x0_ina", alu_ina, 32'h0);
    applyStimulus(1'b1, 32'h108, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'hFFFFF800, 4'h0, 8'h09);
    tick();
    checkOutput("imm_inb", alu_inb, 32'hFFFFF800);
    checkOutput("imm_store", ex_store_data, 32'h0);
    setBypass(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

    // Forwarding priority on x5
    applyStimulus(1'b1, 32'h10C, 5'd5, 5'd0, 5'd8, 32'h99, 32'h0, 32'h0, 4'h0, 8'h08);
    tick();
    setBypass(5'd5, 1'b1, 32'h10, 5'd5, 1'b1, 32'h20);
    #1;
`ifdef IDEX_FWD_EN
    checkOutput("fwd_exmem_wins", alu_ina, 32'h10);
    exmem_reg_write = 1'b0;
    #1 checkOutput("fwd_memwb", alu_ina, 32'h20);
`else
    checkOutput("nofwd_ina", alu_ina, 32'h99);
    checkOutput("nofwd_exmem_stall", {31'b0, hazard_stall}, 32'h1);
`endif
    setBypass(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    #1 checkOutput("regfile_ina", alu_ina, 32'h99);

    // Load-use: lw x7 then add x9,x7,x2
    applyStimulus(1'b1, 32'h110, 5'd1, 5'd0, 5'd7, 32'h1000, 32'h0, 32'h0, 4'h0, 8'h1B);
    tick();
    applyStimulus(1'b1, 32'h114, 5'd7, 5'd2, 5'd9, 32'h77, 32'h22, 32'h0, 4'h0, 8'h08);
    #1 checkOutput("lu_stall", {31'b0, hazard_stall}, 32'h1);
    tick();
    checkOutput("lu_bubble_valid", {31'b0, ex_valid}, 32'h0);
    checkOutput("lu_bubble_ctrl", {24'b0, ex_ctrl}, 32'h0);
    checkOutput("lu_bubble_rd", {27'b0, ex_rd}, 32'h0);
    setBypass(5'd7, 1'b1, 32'h1000, 5'd0, 1'b0, 32'h0);
`ifdef IDEX_FWD_EN
    #1 checkOutput("lu_stall_once", {31'b0, hazard_stall}, 32'h0);
    tick();
    setBypass(5'd0, 1'b0, 32'h0, 5'd7, 1'b1, 32'hABCD);
`else
    #1 checkOutput("lu_stall_exmem", {31'b0, hazard_stall}, 32'h1);
    tick();
    checkOutput("lu_bubble2_valid", {31'b0, ex_valid}, 32'h0);
    setBypass(5'd0, 1'b0, 32'h0, 5'd7, 1'b1, 32'hABCD);
    id_rs1_data = 32'hABCD;
    #1 checkOutput("lu_stall_clear", {31'b0, hazard_stall}, 32'h0);
    tick();
`endif
    #1;
    checkOutput("lu_valid", {31'b0, ex_valid}, 32'h1);
    checkOutput("lu_ina", alu_ina, 32'hABCD);
    checkOutput("lu_inb", alu_inb, 32'h22);

    // Flush beats hold
    setBypass(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h118, 5'd3, 5'd4, 5'd11, 32'h33, 32'h44, 32'h0, 4'h1, 8'h08);
    flush = 1'b1; ex_hold = 1'b1;
    tick();
    checkOutput("flush_valid", {31'b0, ex_valid}, 32'h0);
    checkOutput("flush_ctrl", {24'b0, ex_ctrl}, 32'h0);
    checkOutput("flush_rd", {27'b0, ex_rd}, 32'h0);
    flush = 1'b0; ex_hold = 1'b0;

    // Hold for three cycles while ID changes underneath
    applyStimulus(1'b1, 32'h200, 5'd3, 5'd4, 5'd10, 32'h5, 32'h6, 32'h0, 4'h9, 8'h08);
    tick();
    ex_hold = 1'b1;
    applyStimulus(1'b1, 32'h300, 5'd12, 5'd13, 5'd14, 32'hDEAD, 32'hBEEF, 32'h0, 4'h2, 8'h0C);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold_pc", ex_pc, 32'h200);
      checkOutput("hold_op", {28'b0, alu_op}, 32'h9);
      checkOutput("hold_ina", alu_ina, 32'h5);
      checkOutput("hold_inb", alu_inb, 32'h6);
      checkOutput("hold_rd", {27'b0, ex_rd}, 32'hA);
    end
    ex_hold = 1'b0;

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_valid", {31'b0, ex_valid}, 32'h0);
    checkOutput("async_ctrl", {24'b0, ex_ctrl}, 32'h0);
    checkOutput("async_ina", alu_ina, 32'h0);
    tick();
    rst_n = 1'b1;

`ifndef IDEX_FWD_EN
    // addi x3,x0,5 then add x4,x3,x3 stalls until x3 is in the regfile
    applyStimulus(1'b1, 32'h400, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h5, 4'h0, 8'h09);
    tick();
    applyStimulus(1'b1, 32'h404, 5'd3, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0, 4'h0, 8'h08);
    #1 checkOutput("raw_stall1", {31'b0, hazard_stall}, 32'h1);
    tick();
    setBypass(5'd3, 1'b1, 32'h5, 5'd0, 1'b0, 32'h0);
    #1 checkOutput("raw_stall2", {31'b0, hazard_stall}, 32'h1);
    tick();
    setBypass(5'd0, 1'b0, 32'h0, 5'd3, 1'b1, 32'h5);
    id_rs1_data = 32'h5; id_rs2_data = 32'h5;
    #1 checkOutput("raw_clear", {31'b0, hazard_stall}, 32'h0);
    tick();
    checkOutput("raw_valid", {31'b0, ex_valid}, 32'h1);
    checkOutput("raw_rd", {27'b0, ex_rd}, 32'h4);
    checkOutput("raw_ina", alu_ina, 32'h5);
    checkOutput("raw_inb", alu_inb, 32'h5);
`endif

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
